// File: rtl/window_fetch_ctrl.sv
// 3x3 window sequencer: scans interior centre rows column by column, assembles
// windows from frame memory and delays the centre address to match the filter.
module window_fetch_ctrl #(
   parameter int IMG_W    = 64,
   parameter int IMG_H    = 64,
   parameter int ADDR_W   = 12,
   parameter int PIPE_LAT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              hold,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_data,
   output logic [7:0]        p1,
   output logic [7:0]        p2,
   output logic [7:0]        p3,
   output logic [7:0]        p4,
   output logic [7:0]        p5,
   output logic [7:0]        p6,
   output logic [7:0]        p7,
   output logic [7:0]        p8,
   output logic [7:0]        p9,
   output logic              act,
   output logic              win_valid,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              busy,
   output logic              done
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0]     COL_LAST  = CW'(IMG_W - 1);
   localparam logic [CW-1:0]     COL_TWO   = CW'(2);
   localparam logic [RW-1:0]     ROW_FIRST = RW'(1);
   localparam logic [RW-1:0]     ROW_LAST  = RW'(IMG_H - 2);
   localparam logic [ADDR_W-1:0] STEP_ROW  = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] STEP_COL  = ADDR_W'(2 * IMG_W - 1);
   localparam logic [ADDR_W-1:0] CTR_OFS   = ADDR_W'(IMG_W + 1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       col_q, col_d;
   logic [RW-1:0]       row_q, row_d;
   logic [1:0]          ridx_q, ridx_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                rdv_q;
   logic [1:0]          rd_idx_q;
   logic                rd_ok_q;
   logic [ADDR_W-1:0]   rd_addr_q;
   logic [7:0]          c0_q, c1_q;
   logic [23:0]         prv2_q, prv1_q;
   logic [23:0]         winl_q, winm_q, winr_q;
   logic                wv_q;
   logic [ADDR_W-1:0]   waddr_q;
   logic [PIPE_LAT-1:0] vpipe_q;
   logic [ADDR_W-1:0]   apipe_q [PIPE_LAT];
   logic [PIPE_LAT-1:0] vpend;
   logic [23:0]         col_new;
   logic                col_done;
   logic                win_load;

   assign col_new  = {c0_q, c1_q, mem_data};
   assign col_done = rdv_q && (rd_idx_q == 2'd2);
   assign win_load = col_done && rd_ok_q;

   // Address walks top/mid/bottom of a column, then steps back up and right;
   // the same step also wraps to the next centre row.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      ridx_d  = ridx_q;
      addr_d  = addr_q;
      mem_rd  = 1'b0;
      vpend   = vpipe_q;
      vpend[PIPE_LAT-1] = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FETCH;
               col_d   = '0;
               row_d   = ROW_FIRST;
               ridx_d  = 2'd0;
               addr_d  = '0;
            end
         end
         S_FETCH: begin
            if (!hold) begin
               mem_rd = 1'b1;
               if (ridx_q == 2'd2) begin
                  ridx_d = 2'd0;
                  addr_d = addr_q - STEP_COL;
                  if (col_q == COL_LAST) begin
                     col_d = '0;
                     row_d = row_q + RW'(1);
                     if (row_q == ROW_LAST) state_d = S_DRAIN;
                  end else begin
                     col_d = col_q + CW'(1);
                  end
               end else begin
                  ridx_d = ridx_q + 2'd1;
                  addr_d = addr_q + STEP_ROW;
               end
            end
         end
         S_DRAIN: begin
            if (!rdv_q && !wv_q && (vpend == '0)) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         col_q    <= '0;
         row_q    <= '0;
         ridx_q   <= 2'd0;
         addr_q   <= '0;
         rdv_q    <= 1'b0;
         rd_idx_q <= 2'd0;
         rd_ok_q  <= 1'b0;
         wv_q     <= 1'b0;
         waddr_q  <= '0;
         winl_q   <= '0;
         winm_q   <= '0;
         winr_q   <= '0;
         vpipe_q  <= '0;
         for (int i = 0; i < PIPE_LAT; i++) apipe_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         row_q    <= row_d;
         ridx_q   <= ridx_d;
         addr_q   <= addr_d;
         rdv_q    <= mem_rd;
         rd_idx_q <= ridx_q;
         rd_ok_q  <= (col_q >= COL_TWO);
         wv_q     <= win_load;
         if (win_load) begin
            winl_q  <= prv2_q;
            winm_q  <= prv1_q;
            winr_q  <= col_new;
            waddr_q <= rd_addr_q - CTR_OFS;
         end
         vpipe_q[0] <= wv_q;
         apipe_q[0] <= waddr_q;
         for (int i = 1; i < PIPE_LAT; i++) begin
            vpipe_q[i] <= vpipe_q[i-1];
            apipe_q[i] <= apipe_q[i-1];
         end
      end
   end

   // Column shift state; first two columns of a row are masked by rd_ok_q.
   always_ff @(posedge clk) begin
      if (mem_rd) rd_addr_q <= addr_q;
      if (rdv_q && (rd_idx_q == 2'd0)) c0_q <= mem_data;
      if (rdv_q && (rd_idx_q == 2'd1)) c1_q <= mem_data;
      if (col_done) begin
         prv2_q <= prv1_q;
         prv1_q <= col_new;
      end
   end

   assign p1 = winl_q[23:16];
   assign p2 = winm_q[23:16];
   assign p3 = winr_q[23:16];
   assign p4 = winl_q[15:8];
   assign p5 = winm_q[15:8];
   assign p6 = winr_q[15:8];
   assign p7 = winl_q[7:0];
   assign p8 = winm_q[7:0];
   assign p9 = winr_q[7:0];

   assign mem_addr  = addr_q;
   assign win_valid = wv_q;
   assign act       = wv_q;
   assign wr_en     = vpipe_q[PIPE_LAT-1];
   assign wr_addr   = apipe_q[PIPE_LAT-1];
   assign busy      = (state_q == S_FETCH) || (state_q == S_DRAIN);
   assign done      = (state_q == S_DONE);
endmodule

// File: tb/tb_window_fetch_ctrl.sv
// Randomized bench for window_fetch_ctrl: random image, hold and stray start
// pulses, checked cycle by cycle against a scan-order reference model.
`timescale 1ns/1ps
module tb_window_fetch_ctrl;
   localparam int W    = 5;
   localparam int H    = 5;
   localparam int AW   = 5;
   localparam int PL   = 4;
   localparam int NRD  = (H - 2) * W * 3;
   localparam int NWIN = (W - 2) * (H - 2);
   localparam int RING = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          hold = 1'b0;
   logic          mem_rd;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_data = 8'd0;
   logic [7:0]    p1, p2, p3, p4, p5, p6, p7, p8, p9;
   logic          act, win_valid, wr_en, busy, done;
   logic [AW-1:0] wr_addr;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   logic [7:0] img [1 << AW];

   window_fetch_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .PIPE_LAT(PL)) dut (
      .clk(clk), .rst(rst), .start(start), .hold(hold),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
      .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8), .p9(p9),
      .act(act), .win_valid(win_valid), .wr_en(wr_en), .wr_addr(wr_addr),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // synchronous-read frame memory
   always @(posedge clk) if (mem_rd) mem_data <= img[mem_addr];

   task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic [7:0] pix(input int y, input int x);
      return img[AW'(y * W + x)];
   endfunction

   // k-th read of the frame: column block k/3, row offset k%3 within it
   function automatic logic [AW-1:0] scan_addr(input int k);
      int blk, x, y;
      blk = k / 3;
      x   = blk % W;
      y   = 1 + blk / W;
      return AW'((y - 1 + k % 3) * W + x);
   endfunction

   function automatic logic [71:0] window_at(input int cy, input int cx);
      return {pix(cy-1, cx-1), pix(cy-1, cx), pix(cy-1, cx+1),
              pix(cy,   cx-1), pix(cy,   cx), pix(cy,   cx+1),
              pix(cy+1, cx-1), pix(cy+1, cx), pix(cy+1, cx+1)};
   endfunction

   // Reference model: 0 idle, 1 fetching, 2 waiting for last write, 3 done
   int            cyc = 0;
   int            mst = 0;
   int            mk = 0;
   int            last_wr = 0;
   bit            ev_win [RING];
   logic [71:0]   ev_p   [RING];
   bit            ev_wr  [RING];
   logic [AW-1:0] ev_wa  [RING];
   logic [71:0]   cur_p = '0;
   logic [71:0]   pobs;
   int            wr_cnt = 0;
   bit            frame_over = 1'b0;
   bit            exp_rd;
   int            s, bx, by;

   always @(negedge clk) begin
      pobs = {p1, p2, p3, p4, p5, p6, p7, p8, p9};
      if (!rst) begin
         check_eq("rst_ctrl", 72'({mem_rd, win_valid, act, wr_en, busy, done}), 72'(0));
         check_eq("rst_addr", 72'({mem_addr, wr_addr}), 72'(0));
         check_eq("rst_window", pobs, 72'(0));
         mst = 0; mk = 0; cur_p = '0; wr_cnt = 0;
         for (int i = 0; i < RING; i++) begin
            ev_win[i] = 1'b0;
            ev_wr[i]  = 1'b0;
         end
      end else begin
         s = cyc % RING;
         exp_rd = (mst == 1) && !hold;
         check_eq("mem_rd", 72'(mem_rd), 72'(exp_rd));
         if (exp_rd) check_eq("mem_addr", 72'(mem_addr), 72'(scan_addr(mk)));
         if (ev_win[s]) cur_p = ev_p[s];
         check_eq("win_valid", 72'(win_valid), 72'(ev_win[s]));
         check_eq("act", 72'(act), 72'(ev_win[s]));
         check_eq("window", pobs, cur_p);
         check_eq("wr_en", 72'(wr_en), 72'(ev_wr[s]));
         if (ev_wr[s]) begin
            check_eq("wr_addr", 72'(wr_addr), 72'(ev_wa[s]));
            wr_cnt++;
         end
         check_eq("busy", 72'(busy), 72'((mst == 1) || (mst == 2)));
         check_eq("done", 72'(done), 72'(mst == 3));
         if (mst == 3) begin
            check_eq("wr_count", 72'(wr_cnt), 72'(NWIN));
            wr_cnt = 0;
            frame_over = 1'b1;
         end
         ev_win[s] = 1'b0;
         ev_wr[s]  = 1'b0;
         case (mst)
            0: if (start) begin mst = 1; mk = 0; end
            1: if (!hold) begin
               bx = (mk / 3) % W;
               by = 1 + (mk / 3) / W;
               if ((mk % 3 == 2) && (bx >= 2)) begin
                  ev_win[(cyc + 2) % RING]    = 1'b1;
                  ev_p[(cyc + 2) % RING]      = window_at(by, bx - 1);
                  ev_wr[(cyc + 2 + PL) % RING] = 1'b1;
                  ev_wa[(cyc + 2 + PL) % RING] = AW'(by * W + bx - 1);
               end
               mk++;
               if (mk == NRD) begin
                  mst = 2;
                  last_wr = cyc + 2 + PL;
               end
            end
            2: if (cyc == last_wr) mst = 3;
            default: mst = 0;
         endcase
      end
      cyc++;
   end

   task automatic tick(input logic st, input logic hd);
      @(posedge clk);
      #1;
      start = st;
      hold  = hd;
   endtask

   task automatic run_frame(input int hold_pct, input int poke_pct);
      int n;
      for (int i = 0; i < (1 << AW); i++) img[i] = 8'($urandom);
      frame_over = 1'b0;
      tick(1'b1, 1'b0);
      n = 0;
      while (!frame_over && n < 1000) begin
         tick($urandom_range(0, 99) < poke_pct, $urandom_range(0, 99) < hold_pct);
         n++;
      end
      if (!frame_over) check_eq("frame_timeout", 72'(0), 72'(1));
      tick(1'b0, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) img[i] = 8'($urandom);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      tick(1'b0, 1'b0);
      run_frame(0, 0);
      run_frame(0, 10);
      for (int f = 0; f < 4; f++) run_frame(30, 10);
      run_frame(50, 100);
      // abort mid-frame, then rerun from address 0
      tick(1'b1, 1'b0);
      repeat (11) tick(1'b0, 1'b0);
      @(posedge clk);
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (10) tick(1'b0, 1'b0);
      run_frame(0, 0);
      run_frame(20, 10);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
